// File: rtl/uart_pio_key_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// Bus semantics: a write takes effect on the clock edge where chipselect=1 and
// write_n=0 are both sampled; readdata always reflects the register selected by
// address on the previous edge (read latency 1, no read strobe, no side effects).
// There is no waitrequest, so every access completes in exactly one cycle.
interface uart_pio_key_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/uart_pio_key.sv
// Input PIO for the push-button/switch bank: synchronizes the raw pins,
// debounces each bit, detects edges into a sticky write-1-to-clear capture
// register and raises a level interrupt for captured bits that are unmasked.
module uart_pio_key #(
  parameter int                WIDTH           = 4,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter int                EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0]  IN_RESET_VAL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_pio_key_if.slave    bus,
  input  logic [WIDTH-1:0] in_port
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_q;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic             wr_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [31:0]      rd_mux;

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Two-flop synchronizer; reset to the idle pin level so no edge appears at release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IN_RESET_VAL;
      sync2 <= IN_RESET_VAL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES samples; any bounce restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= IN_RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Edge selection on the filtered level and decode of the write-1-to-clear strobe.
  always_comb begin
    rise = stable & ~stable_q;
    fall = ~stable & stable_q;
    if (EDGE_TYPE == 0)      ev = rise;
    else if (EDGE_TYPE == 1) ev = fall;
    else                     ev = rise | fall;
    clr = '0;
    if (wr_en && bus.address == 2'd3) clr = bus.writedata[WIDTH-1:0];
  end

  // Delayed level for edge detection, sticky capture (set beats clear) and the mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q     <= IN_RESET_VAL;
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      stable_q     <= stable;
      edge_capture <= (edge_capture & ~clr) | ev;
      if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  // Zero-extended read mux; address 1 is reserved and reads as zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, refreshed every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

  // Level interrupt straight from registers, so it drops asynchronously with reset.
  assign bus.irq = |(edge_capture & irq_mask);

endmodule

// File: doc/uart_pio_key.md
Name: uart_pio_key

Overview:
- Avalon-MM slave input PIO for the push-button/switch bank on the Nios II UART system.
- Counterpart to the 4-bit LED output PIO: it samples external inputs instead of driving them.
- Samples WIDTH external pins through a 2-flop synchronizer, a per-bit debounce filter and edge detection.
- Exposes the filtered level, a per-bit interrupt mask and a sticky edge-capture register, and drives a level interrupt to the CPU.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a new level must persist before acceptance; minimum 1, where 1 means no filtering.
- EDGE_TYPE, 2, edge that sets capture: 0 = rising, 1 = falling, 2 = any.
- IN_RESET_VAL, {WIDTH{1'b1}}, reset value of synchronizer and filtered-level registers; inputs idle high (active-low keys).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- address  input  2  word address: 0 data, 2 irqmask, 3 edgecapture; 1 reserved.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, valid with chipselect.
- writedata  input  32  write data; bits [WIDTH-1:0] used.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Reset and clock: reset_n is asynchronous and active-low; clk is the clock.
- Reset values:
  - sync1, sync2, stable and stable_q = IN_RESET_VAL.
  - debounce counters = 0; irq_mask = 0; edge_capture = 0.
  - readdata = 0; irq = 0.
  - No spurious edge may be captured after reset release while in_port stays at IN_RESET_VAL.
- Synchronizer: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit i, with counter width clog2(DEBOUNCE_CYCLES)+1:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES is discarded; a bounce resets the count.
  - Latency from an in_port change to stable: 2 + DEBOUNCE_CYCLES clocks, minimum 3.
- Edge detection: stable_q <= stable every cycle.
  - rise = stable & ~stable_q; fall = ~stable & stable_q.
  - ev = rise, fall or rise|fall, selected by EDGE_TYPE.
- Edge capture:
  - Each cycle: edge_capture <= (edge_capture & ~clr) | ev.
  - clr = writedata[WIDTH-1:0] when chipselect & ~write_n & address==3, else 0.
  - Write-1-to-clear; writing 0 leaves a bit unchanged.
  - If an edge and a clear hit the same bit in the same cycle, set wins.
- irq_mask: written on chipselect & ~write_n & address==2 with writedata[WIDTH-1:0].
- irq = |(edge_capture & irq_mask), combinational from registers only.
  - irq rises 1 clock after the ev cycle.
  - irq deasserts the cycle after a clear write, unless set wins.
- Writes to address 0 and 1 are ignored.
- Read: every cycle, readdata <= zero-extended mux:
  - address 0: stable.
  - address 2: irq_mask.
  - address 3: edge_capture.
  - address 1: 0.
  - Read latency is 1; no read strobe is needed because reads have no side effects.
  - Bits [31:WIDTH] always read 0.
- Reset mid-operation: all state returns to the reset values at once and irq drops asynchronously.

Test Plan:
- Reset: hold in_port=4'hF and release reset_n → readdata addr0 = 0x0000000F, addr3 = 0, irq = 0 for 100 cycles.
- Debounce with DEBOUNCE_CYCLES=8 and EDGE_TYPE=1:
  - in_port[0] driven low for 7 cycles then high → addr0 stays 0xF and no capture.
  - in_port[0] held low for 8 cycles → addr0 = 0xE after 10 clocks and addr3 = 0x1.
- Bounce: toggle in_port[2] low/high every 3 cycles for 30 cycles, then hold low → exactly one capture (addr3 = 0x4), and stable changes only after 8 quiet cycles.
- IRQ: irq_mask = 0x2 and a bit1 falling edge → irq = 1; bit3 edge with the mask bit clear → addr3 = 0xA and irq remains driven by bit1 only. Write 0x2 to addr3 → irq = 0 and addr3 = 0x8.
- Simultaneous event: write 0x1 to addr3 in the exact cycle ev[0] asserts → edge_capture[0] stays 1 and irq stays high.
- EDGE_TYPE=2 and WIDTH=4: press and release key3 → capture set on both edges; writes to addr0 and addr1 have no effect; addr1 reads 0.
